// File: rtl/exp_log_pkg.sv
// Shared definitions for the integer-logarithm unit (exp_log_fsmd).
// Holds the controller state encoding and the default widths used by the
// top level and the datapath:
//   XW_DEF : width of the value x (matches the exponent unit's result width)
//   AW_DEF : width of the base a
//   NW_DEF : width of the result exponent n
package exp_log_pkg;

    localparam int XW_DEF = 16;
    localparam int AW_DEF = 8;
    localparam int NW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : exp_log_pkg

// File: rtl/exp_log_datapath.sv
// Datapath for exp_log_fsmd: operand registers, running power and step count.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   ld_i           register-update strobe from the controller
//   sel_i          update source: 0 = load operands from a_i/x_i and restart
//                  (acc = 1, cnt = 0), 1 = accept one multiply step
//                  (acc = acc*a, cnt = cnt+1)
//   a_i, x_i       base and value, captured when ld_i && !sel_i
//   le_o           acc*a_reg <= x_reg (the next power still fits under x)
//   eq_o           acc == x_reg (x is an exact power of a)
//   cnt_o          number of accepted steps so far
module exp_log_datapath
    import exp_log_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int AW = AW_DEF,
    parameter int NW = NW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_i,
    input  logic          sel_i,
    input  logic [AW-1:0] a_i,
    input  logic [XW-1:0] x_i,
    output logic          le_o,
    output logic          eq_o,
    output logic [NW-1:0] cnt_o
);

    logic [AW-1:0]    a_q;
    logic [XW-1:0]    x_q;
    logic [XW-1:0]    acc_q;
    logic [NW-1:0]    cnt_q;
    logic [XW+AW-1:0] prod;

    // Full-width product: acc <= x < 2^XW and a < 2^AW, so it never wraps,
    // and the overshooting product that ends the loop compares correctly.
    assign prod  = acc_q * a_q;
    assign le_o  = (prod <= {{AW{1'b0}}, x_q});
    assign eq_o  = (acc_q == x_q);
    assign cnt_o = cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the clock edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            x_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (ld_i) begin
            if (sel_i) begin
                // Only taken when le_o is high, so the product fits in XW bits.
                acc_q <= prod[XW-1:0];
                cnt_q <= cnt_q + 1'b1;
            end else begin
                a_q   <= a_i;
                x_q   <= x_i;
                acc_q <= XW'(1);
                cnt_q <= '0;
            end
        end
    end

endmodule : exp_log_datapath

// File: rtl/exp_log_fsmd.sv
// Integer logarithm: n = floor(log_a(x)), the largest n with a^n <= x,
// computed by repeated multiply-and-compare, one step per clock.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      request, sampled only while idle
//   a_i, x_i   base and value, captured on the accepting edge
//   n_o        registered result exponent
//   exact_o    registered; 1 when a^n_o == x
//   err_o      registered; 1 when a < 2 or x == 0 (n_o and exact_o then 0)
//   busy       high whenever a computation is in flight
//   done       one-cycle pulse when the result registers have just updated
module exp_log_fsmd
    import exp_log_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int AW = AW_DEF,
    parameter int NW = NW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] a_i,
    input  logic [XW-1:0] x_i,
    output logic [NW-1:0] n_o,
    output logic          exact_o,
    output logic          err_o,
    output logic          busy,
    output logic          done
);

    state_t        state_q, state_d;
    logic [NW-1:0] n_q, n_d;
    logic          exact_q, exact_d;
    logic          err_q, err_d;
    logic          dp_ld, dp_sel;
    logic          dp_le, dp_eq;
    logic [NW-1:0] dp_cnt;

    exp_log_datapath #(
        .XW(XW),
        .AW(AW),
        .NW(NW)
    ) u_datapath (
        .clk   (clk),
        .rst   (rst),
        .ld_i  (dp_ld),
        .sel_i (dp_sel),
        .a_i   (a_i),
        .x_i   (x_i),
        .le_o  (dp_le),
        .eq_o  (dp_eq),
        .cnt_o (dp_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            exact_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            exact_q <= exact_d;
            err_q   <= err_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        exact_d = exact_q;
        err_d   = err_q;
        dp_ld   = 1'b0;
        dp_sel  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dp_ld = 1'b1;
                    // Degenerate operands have no finite answer: skip the
                    // loop and report the error directly.
                    if (a_i < AW'(2) || x_i == '0) begin
                        n_d     = '0;
                        exact_d = 1'b0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = STEP;
                    end
                end
            end
            STEP: begin
                if (dp_le) begin
                    dp_ld  = 1'b1;
                    dp_sel = 1'b1;
                end else begin
                    n_d     = dp_cnt;
                    exact_d = dp_eq;
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign n_o     = n_q;
    assign exact_o = exact_q;
    assign err_o   = err_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule : exp_log_fsmd

// File: tb/tb_exp_log_fsmd.sv
// Directed self-checking bench for exp_log_fsmd. Inputs change on the falling
// edge; outputs are sampled on the falling edge. Cycle 0 is the cycle in which
// start is high, so the first falling edge after acceptance is cycle 1.
module tb_exp_log_fsmd;

    localparam int XW = 16;
    localparam int AW = 8;
    localparam int NW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] a_i;
    logic [XW-1:0] x_i;
    logic [NW-1:0] n_o;
    logic          exact_o;
    logic          err_o;
    logic          busy;
    logic          done;

    int tests = 0;
    int fails = 0;

    exp_log_fsmd #(
        .XW(XW),
        .AW(AW),
        .NW(NW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_i     (a_i),
        .x_i     (x_i),
        .n_o     (n_o),
        .exact_o (exact_o),
        .err_o   (err_o),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to done (bounded), checking latency,
    // results, busy rise and the single-cycle done pulse.
    task automatic run_case(input string tag, input logic [AW-1:0] a, input logic [XW-1:0] x,
                            input int exp_n, input logic exp_exact, input logic exp_err,
                            input int exp_cyc);
        int  cyc;
        bit  got;
        @(negedge clk);
        a_i   = a;
        x_i   = x;
        start = 1'b1;
        cyc   = 0;
        got   = 1'b0;
        while (cyc < 40 && !got) begin
            @(negedge clk);
            start = 1'b0;
            // Operands may change freely once accepted.
            a_i   = AW'($urandom);
            x_i   = XW'($urandom);
            cyc++;
            if (cyc == 1) check({tag, " busy_rise"}, 32'(busy), 32'd1);
            if (done) got = 1'b1;
        end
        check({tag, " done_seen"}, 32'(got), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(exp_cyc));
        check({tag, " n"}, 32'(n_o), 32'(exp_n));
        check({tag, " exact"}, 32'(exact_o), 32'(exp_exact));
        check({tag, " err"}, 32'(err_o), 32'(exp_err));
        @(negedge clk);
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " busy_fall"}, 32'(busy), 32'd0);
        check({tag, " n_held"}, 32'(n_o), 32'(exp_n));
    endtask

    initial begin
        int  cyc;
        bit  got;
        bit  saw_done;

        rst   = 1'b1;
        start = 1'b0;
        a_i   = '0;
        x_i   = '0;
        repeat (2) @(negedge clk);
        check("reset n", 32'(n_o), 32'd0);
        check("reset exact", 32'(exact_o), 32'd0);
        check("reset err", 32'(err_o), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Normal, inexact, 24-bit-product, exact and trivial cases.
        run_case("a2_x1024",   8'd2,   16'd1024,  10, 1'b1, 1'b0, 12);
        run_case("a3_x100",    8'd3,   16'd100,    4, 1'b0, 1'b0,  6);
        run_case("a2_x65535",  8'd2,   16'd65535, 15, 1'b0, 1'b0, 17);
        run_case("a255_x65025",8'd255, 16'd65025,  2, 1'b1, 1'b0,  4);
        run_case("a7_x1",      8'd7,   16'd1,      0, 1'b1, 1'b0,  2);
        // Error cases.
        run_case("err_a1",     8'd1,   16'd50,     0, 1'b0, 1'b1,  1);
        run_case("err_x0",     8'd5,   16'd0,      0, 1'b0, 1'b1,  1);
        run_case("a10_x9999",  8'd10,  16'd9999,   3, 1'b0, 1'b0,  5);

        // start re-pulsed while busy must be ignored.
        @(negedge clk);
        a_i   = 8'd2;
        x_i   = 16'd1024;
        start = 1'b1;
        cyc   = 0;
        got   = 1'b0;
        while (cyc < 40 && !got) begin
            @(negedge clk);
            cyc++;
            if (cyc == 4) begin
                start = 1'b1;
                a_i   = 8'd3;
                x_i   = 16'd100;
            end else begin
                start = 1'b0;
            end
            if (done) got = 1'b1;
        end
        check("ignore done_seen", 32'(got), 32'd1);
        check("ignore latency", 32'(cyc), 32'd12);
        check("ignore n", 32'(n_o), 32'd10);
        check("ignore exact", 32'(exact_o), 32'd1);
        @(negedge clk);
        check("ignore no_requeue", 32'(busy), 32'd0);

        // Reset in the middle of a computation.
        @(negedge clk);
        a_i   = 8'd2;
        x_i   = 16'd1024;
        start = 1'b1;
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("midrst busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst n", 32'(n_o), 32'd0);
        check("midrst exact", 32'(exact_o), 32'd0);
        check("midrst err", 32'(err_o), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("midrst no_done", 32'(saw_done), 32'd0);
        run_case("after_rst_a3_x100", 8'd3, 16'd100, 4, 1'b0, 1'b0, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule : tb_exp_log_fsmd
